// File: rtl/prbs7_checker.sv
// PRBS7 (x^7+x^6+1) word checker: self-synchronises on the incoming stream,
// then checks against a free-running local reference and accumulates BER stats.
module prbs7_checker #(
  parameter int WORDWIDTH        = 16,
  parameter int ERRCNT_WIDTH     = 16,
  parameter int WORDCNT_WIDTH    = 32,
  parameter int LOCK_THRESHOLD   = 4,
  parameter int UNLOCK_THRESHOLD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [WORDWIDTH-1:0]     din,
  input  logic                     clr_cnt,
  output logic                     locked,
  output logic [WORDWIDTH-1:0]     err_word,
  output logic                     err_flag,
  output logic [ERRCNT_WIDTH-1:0]  err_cnt,
  output logic [WORDCNT_WIDTH-1:0] word_cnt
);

  localparam int W     = WORDWIDTH;
  localparam int PC_W  = $clog2(W + 1);
  localparam int SUM_W = ((ERRCNT_WIDTH > PC_W) ? ERRCNT_WIDTH : PC_W) + 1;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [6:0]               hist_q, hist_d;
  logic [6:0]               ref_q, ref_d;
  logic [3:0]               good_cnt_q, good_cnt_d;
  logic [3:0]               bad_cnt_q, bad_cnt_d;
  logic                     locked_q, locked_d;
  logic [W-1:0]             err_word_q, err_word_d;
  logic                     err_flag_q, err_flag_d;
  logic [ERRCNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [WORDCNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

  logic [W-1:0]    m_vec, e_vec, r_vec;
  logic            word_good, ref_err;
  logic [PC_W-1:0] r_pop;
  logic [SUM_W-1:0] err_sum;

  // Both predictors apply b[n] = b[n-7] ^ b[n-6] across the word; the
  // self-sync one seeds from received history, the reference from ref_q.
  always_comb begin : predict
    logic [W+6:0] x_vec;
    logic [W+6:0] y_vec;
    // NOTE: every variable gets a default before any conditional or partial
    // write, otherwise synthesis infers a latch to hold the old value.
    x_vec      = {din, hist_q};
    y_vec      = '0;
    y_vec[6:0] = ref_q;
    m_vec      = '0;
    r_pop      = '0;
    for (int j = 0; j < W; j++) begin
      m_vec[j]     = din[j] ^ x_vec[j] ^ x_vec[j+1];
      y_vec[j + 7] = y_vec[j] ^ y_vec[j+1];
    end
    e_vec = y_vec[W+6:7];
    r_vec = din ^ e_vec;
    for (int j = 0; j < W; j++) begin
      r_pop = r_pop + PC_W'(r_vec[j]);
    end
    // An all-zero tail would self-predict zeros forever; PRBS7 never has 7.
    word_good = (m_vec == '0) && (din[W-1:W-7] != 7'd0);
    ref_err   = |r_vec;
    err_sum   = SUM_W'(err_cnt_q) + SUM_W'(r_pop);
  end

  always_comb begin : next_state
    state_d    = state_q;
    ref_d      = ref_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (en) begin
      unique case (state_q)
        SEARCH: begin
          if (!word_good) begin
            good_cnt_d = '0;
          end else if (good_cnt_q + 4'd1 == 4'(LOCK_THRESHOLD)) begin
            state_d    = LOCKED;
            ref_d      = din[W-1:W-7];
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end else begin
            good_cnt_d = good_cnt_q + 4'd1;
          end
        end
        LOCKED: begin
          ref_d = e_vec[W-1:W-7];
          if (!ref_err) begin
            bad_cnt_d = '0;
          end else if (bad_cnt_q + 4'd1 == 4'(UNLOCK_THRESHOLD)) begin
            state_d    = SEARCH;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end else begin
            bad_cnt_d = bad_cnt_q + 4'd1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_comb begin : outputs
    hist_d     = hist_q;
    locked_d   = locked_q;
    err_word_d = err_word_q;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    if (en) begin
      hist_d   = din[W-1:W-7];
      locked_d = (state_d == LOCKED);
      if (state_q == LOCKED) begin
        err_word_d = r_vec;
        err_flag_d = ref_err;
        if (word_cnt_q != '1) word_cnt_d = word_cnt_q + WORDCNT_WIDTH'(1);
        err_cnt_d = (err_sum > SUM_W'({ERRCNT_WIDTH{1'b1}})) ? '1 : err_sum[ERRCNT_WIDTH-1:0];
      end else begin
        err_word_d = m_vec;
        err_flag_d = |m_vec;
      end
      if (clr_cnt) begin
        err_cnt_d  = '0;
        word_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q    <= SEARCH;
      hist_q     <= '0;
      ref_q      <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      locked_q   <= 1'b0;
      err_word_q <= '0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      ref_q      <= ref_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      locked_q   <= locked_d;
      err_word_q <= err_word_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign locked   = locked_q;
  assign err_word = err_word_q;
  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: two configurations driven by one stream, each
// compared every word against a bit-serial reference model of the checker.
module tb_prbs7_checker;

  localparam int     W    = 16;
  localparam longint WMAX = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, en, clr_cnt;
  logic [W-1:0] din;

  logic         locked_a, err_flag_a, locked_b, err_flag_b;
  logic [W-1:0] err_word_a, err_word_b;
  logic [15:0]  err_cnt_a;
  logic [3:0]   err_cnt_b;
  logic [31:0]  word_cnt_a, word_cnt_b;

  prbs7_checker #(.WORDWIDTH(W), .ERRCNT_WIDTH(16), .WORDCNT_WIDTH(32),
                  .LOCK_THRESHOLD(4), .UNLOCK_THRESHOLD(4)) dut_a (
    .clk(clk), .reset(reset), .en(en), .din(din), .clr_cnt(clr_cnt),
    .locked(locked_a), .err_word(err_word_a), .err_flag(err_flag_a),
    .err_cnt(err_cnt_a), .word_cnt(word_cnt_a));

  prbs7_checker #(.WORDWIDTH(W), .ERRCNT_WIDTH(4), .WORDCNT_WIDTH(32),
                  .LOCK_THRESHOLD(4), .UNLOCK_THRESHOLD(15)) dut_b (
    .clk(clk), .reset(reset), .en(en), .din(din), .clr_cnt(clr_cnt),
    .locked(locked_b), .err_word(err_word_b), .err_flag(err_flag_b),
    .err_cnt(err_cnt_b), .word_cnt(word_cnt_b));

  typedef struct packed {
    logic         locked;
    int           good;
    int           bad;
    longint       errcnt;
    longint       wordcnt;
    logic [W-1:0] err_word;
    logic         err_flag;
    logic [6:0]   hist;
    logic [6:0]   refw;
  } mdl_t;

  mdl_t ma, mb;
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   gq[$];

  // Next PRBS7 word from the generator bit queue (oldest bit at index 0).
  task automatic gen_word(output logic [W-1:0] w);
    bit nb;
    for (int j = 0; j < W; j++) begin
      nb = gq[0] ^ gq[1];
      gq.push_back(nb);
      void'(gq.pop_front());
      w[j] = nb;
    end
  endtask

  function automatic mdl_t mdl_next(mdl_t s, logic [W-1:0] d, bit e, bit c, bit r,
                                    int lth, int uth, longint emax);
    mdl_t         n;
    bit           x[$];
    bit           y[$];
    logic [W-1:0] m, ex, rv;
    longint       sum;
    n = s;
    if (!r) begin
      n = '0;
      return n;
    end
    if (!e) return n;
    for (int i = 0; i < 7; i++) begin
      x.push_back(s.hist[i]);
      y.push_back(s.refw[i]);
    end
    for (int j = 0; j < W; j++) x.push_back(d[j]);
    for (int j = 0; j < W; j++) begin
      m[j] = d[j] ^ x[j] ^ x[j+1];
      y.push_back(y[j] ^ y[j+1]);
      ex[j] = y[j+7];
    end
    rv     = d ^ ex;
    n.hist = d[W-1:W-7];
    if (!s.locked) begin
      n.err_word = m;
      n.err_flag = (m != 0);
      if (m == 0 && d[W-1:W-7] != 0) begin
        if (s.good + 1 == lth) begin
          n.locked = 1'b1;
          n.refw   = d[W-1:W-7];
          n.good   = 0;
          n.bad    = 0;
        end else begin
          n.good = s.good + 1;
        end
      end else begin
        n.good = 0;
      end
    end else begin
      n.refw     = ex[W-1:W-7];
      n.err_word = rv;
      n.err_flag = (rv != 0);
      n.wordcnt  = (s.wordcnt + 1 > WMAX) ? WMAX : s.wordcnt + 1;
      sum        = s.errcnt + longint'($countones(rv));
      n.errcnt   = (sum > emax) ? emax : sum;
      if (rv != 0) begin
        if (s.bad + 1 == uth) begin
          n.locked = 1'b0;
          n.good   = 0;
          n.bad    = 0;
        end else begin
          n.bad = s.bad + 1;
        end
      end else begin
        n.bad = 0;
      end
    end
    if (c) begin
      n.errcnt  = 0;
      n.wordcnt = 0;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("a_locked",   64'(locked_a),   64'(ma.locked));
    check("a_err_word", 64'(err_word_a), 64'(ma.err_word));
    check("a_err_flag", 64'(err_flag_a), 64'(ma.err_flag));
    check("a_err_cnt",  64'(err_cnt_a),  ma.errcnt);
    check("a_word_cnt", 64'(word_cnt_a), ma.wordcnt);
    check("b_locked",   64'(locked_b),   64'(mb.locked));
    check("b_err_word", 64'(err_word_b), 64'(mb.err_word));
    check("b_err_flag", 64'(err_flag_b), 64'(mb.err_flag));
    check("b_err_cnt",  64'(err_cnt_b),  mb.errcnt);
    check("b_word_cnt", 64'(word_cnt_b), mb.wordcnt);
  endtask

  // Apply one word at the falling edge, advance both models at the rising
  // edge, compare just after it.
  task automatic step(input logic [W-1:0] d, input bit e, input bit c, input bit r);
    @(negedge clk);
    din = d; en = e; clr_cnt = c; reset = r;
    @(posedge clk);
    ma = mdl_next(ma, d, e, c, r, 4, 4, 64'hFFFF);
    mb = mdl_next(mb, d, e, c, r, 4, 15, 64'hF);
    #1;
    check_all();
  endtask

  initial begin
    logic [W-1:0] w;
    bit           seen;
    longint       wc0;

    for (int i = 0; i < 7; i++) gq.push_back(1'b1);
    ma = '0; mb = '0;
    din = '0; en = 1'b0; clr_cnt = 1'b0; reset = 1'b0;

    step('0, 1'b1, 1'b1, 1'b0);
    step(16'hA5A5, 1'b1, 1'b0, 1'b0);
    check("rst_locked", 64'(locked_a), 64'd0);
    check("rst_errcnt", 64'(err_cnt_a), 64'd0);

    // Lock on a clean stream: first word fails against zero history.
    for (int k = 1; k <= 5; k++) begin
      gen_word(w);
      step(w, 1'b1, 1'b0, 1'b1);
      if (k == 4) check("lock_w4", 64'(locked_a), 64'd0);
      if (k == 5) check("lock_w5", 64'(locked_a), 64'd1);
    end
    seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      gen_word(w);
      step(w, 1'b1, 1'b0, 1'b1);
      seen |= err_flag_a;
    end
    check("clean_errcnt", 64'(err_cnt_a), 64'd0);
    check("clean_wordcnt", 64'(word_cnt_a), 64'd1000);
    check("clean_flag_seen", 64'(seen), 64'd0);

    // Single flipped bit while locked.
    gen_word(w);
    step(w ^ 16'h0008, 1'b1, 1'b0, 1'b1);
    check("sbe_word", 64'(err_word_a), 64'h0008);
    check("sbe_flag", 64'(err_flag_a), 64'd1);
    check("sbe_cnt", 64'(err_cnt_a), 64'd1);
    check("sbe_locked", 64'(locked_a), 64'd1);
    gen_word(w);
    step(w, 1'b1, 1'b0, 1'b1);
    check("sbe_flag_clear", 64'(err_flag_a), 64'd0);

    // Sparse random single-bit flips, never on consecutive words.
    for (int k = 0; k < 40; k++) begin
      gen_word(w);
      if (k % 2 == 0 && $urandom_range(0, 1) == 1)
        w[$urandom_range(0, W-1)] ^= 1'b1;
      step(w, 1'b1, 1'b0, 1'b1);
    end
    check("rand_locked", 64'(locked_a), 64'd1);

    // Loss of lock after four inverted words.
    for (int k = 1; k <= 4; k++) begin
      gen_word(w);
      step(~w, 1'b1, 1'b0, 1'b1);
      if (k == 3) check("unlock_w3", 64'(locked_a), 64'd1);
    end
    check("unlock_w4", 64'(locked_a), 64'd0);
    check("b_sat_inv", 64'(err_cnt_b), 64'hF);
    check("b_hold_lock", 64'(locked_b), 64'd1);
    wc0 = ma.wordcnt;
    for (int k = 0; k < 3; k++) begin
      gen_word(w);
      step(w, 1'b1, 1'b0, 1'b1);
    end
    check("search_wordcnt_frozen", 64'(word_cnt_a), wc0);
    for (int k = 0; k < 5; k++) begin
      gen_word(w);
      step(w, 1'b1, 1'b0, 1'b1);
    end
    check("relock", 64'(locked_a), 64'd1);

    // Clear together with an errored word, then continuous 2-bit errors.
    gen_word(w);
    step(w ^ 16'h0101, 1'b1, 1'b1, 1'b1);
    check("clr_errcnt", 64'(err_cnt_a), 64'd0);
    check("clr_wordcnt", 64'(word_cnt_a), 64'd0);
    check("clr_errword", 64'(err_word_a), 64'h0101);
    for (int k = 1; k <= 13; k++) begin
      gen_word(w);
      step(w ^ (16'h0101 << (k % 8)), 1'b1, 1'b0, 1'b1);
    end
    check("b_sat_locked", 64'(locked_b), 64'd1);
    check("b_sat_cnt", 64'(err_cnt_b), 64'hF);
    check("a_dropped", 64'(locked_a), 64'd0);
    gen_word(w);
    step(w ^ 16'h8080, 1'b1, 1'b0, 1'b1);
    check("b_unlock_15", 64'(locked_b), 64'd0);

    for (int k = 0; k < 10; k++) begin
      gen_word(w);
      step(w, 1'b1, 1'b0, 1'b1);
    end
    check("relock_a", 64'(locked_a), 64'd1);
    check("relock_b", 64'(locked_b), 64'd1);

    // en gaps carrying random garbage must not disturb anything.
    wc0 = ma.wordcnt;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) begin
        gen_word(w);
        step(w, 1'b1, 1'b0, 1'b1);
      end else begin
        step(W'($urandom), 1'b0, 1'b0, 1'b1);
      end
    end
    check("gap_locked", 64'(locked_a), 64'd1);
    check("gap_wordcnt", 64'(word_cnt_a), wc0 + 20);

    // Reset while locked.
    gen_word(w);
    step(w ^ 16'h0010, 1'b1, 1'b0, 1'b0);
    check("midrst_locked", 64'(locked_a), 64'd0);
    check("midrst_errcnt", 64'(err_cnt_a), 64'd0);
    check("midrst_wordcnt", 64'(word_cnt_a), 64'd0);
    check("midrst_locked_b", 64'(locked_b), 64'd0);

    // All-zero and all-one input never lock.
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step('0, 1'b1, 1'b0, 1'b1);
      seen |= locked_a | locked_b;
    end
    check("zero_no_lock", 64'(seen), 64'd0);
    for (int k = 0; k < 20; k++) begin
      step('1, 1'b1, 1'b0, 1'b1);
      seen |= locked_a | locked_b;
    end
    check("ones_no_lock", 64'(seen), 64'd0);
    check("ones_flag", 64'(err_flag_a), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
